// File: rtl/odd_parity_frame_tx.sv
// Serial frame transmitter: start bit, 4 data bits LSB first, supplied parity, stop bit(s).
// Flags a parity mismatch at handshake but always sends the parity it was given.
module odd_parity_frame_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d_in,
  input  logic       p_in,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, next_state;
  logic [CW-1:0] timer;
  logic [1:0]    bit_idx;
  logic [3:0]    shift;
  logic          par_q;
  logic          stop_cnt;
  logic          bit_tick;
  logic          last_stop;
  logic          accept;

  assign bit_tick  = (timer == TMAX);
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_cnt;
  assign accept    = (state == IDLE) && valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (valid)                         next_state = START;
      START:   if (bit_tick)                      next_state = DATA;
      DATA:    if (bit_tick && bit_idx == 2'd3)   next_state = PARITY;
      PARITY:  if (bit_tick)                      next_state = STOP;
      STOP:    if (bit_tick && last_stop)         next_state = IDLE;
      default:                                    next_state = IDLE;
    endcase
  end

  always_comb begin
    tx    = 1'b1;
    ready = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      START:   tx    = 1'b0;
      DATA:    tx    = shift[0];
      PARITY:  tx    = par_q;
      STOP:    done  = bit_tick && last_stop;
      default: ready = 1'b0;
    endcase
  end

  assign busy = ~ready;

  // Timer and bit counters are held clear in IDLE so every frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_q    <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_err <= 1'b0;
      if (state == IDLE) begin
        timer    <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
        if (accept) begin
          shift   <= d_in;
          par_q   <= p_in;
          // mismatch when p_in differs from ~^d_in, i.e. equals ^d_in
          par_err <= (p_in == ^d_in);
        end
      end else begin
        timer <= bit_tick ? '0 : timer + 1'b1;
        if (bit_tick) begin
          if (state == DATA) begin
            shift   <= {1'b0, shift[3:1]};
            bit_idx <= bit_idx + 2'd1;
          end
          if (state == STOP) stop_cnt <= ~stop_cnt;
        end
      end
    end
  end

endmodule
